// File: rtl/div_sel_ctrl.sv
// rtl/div_sel_ctrl.sv - glitch-free programmable clock divider with 4-phase select handshake
// Ratio changes are deferred to the last cycle of the current div_out period.
module div_sel_ctrl #(
    parameter logic [2:0] DEFAULT_SEL = 3'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sel_req,
    input  logic [2:0] sel_val,
    output logic       sel_ack,
    output logic       sel_err,
    output logic       busy,
    output logic [2:0] cur_sel,
    output logic       div_out,
    output logic       div_tick
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ACK     = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [2:0] cur_sel_q, cur_sel_d;
    logic [2:0] pend_sel_q, pend_sel_d;
    logic       err_d;
    logic       div_out_q, div_out_d;
    logic       div_tick_q;
    logic       sel_ack_q;
    logic       sel_err_q;
    logic       busy_q;
    logic [5:0] span;
    logic       boundary;
    logic [7:0] cnt_ext;

    // Low (cur_sel+1) bits all ones marks the final cycle of the current period.
    assign span     = (6'd2 << cur_sel_q) - 6'd1;
    assign boundary = ((cnt_q & span[4:0]) == span[4:0]);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 5'd1;
        cur_sel_d  = cur_sel_q;
        pend_sel_d = pend_sel_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_req) begin
                    if (sel_val > 3'd4) begin
                        err_d   = 1'b1;
                        state_d = ACK;
                    end else if (sel_val == cur_sel_q) begin
                        state_d = ACK;
                    end else begin
                        pend_sel_d = sel_val;
                        state_d    = PENDING;
                    end
                end
            end
            PENDING: begin
                if (boundary) begin
                    cnt_d     = 5'd0;
                    cur_sel_d = pend_sel_q;
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (!sel_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // div_out is precomputed from next-state values so the output comes straight off a flop.
    assign cnt_ext   = {3'b000, cnt_d};
    assign div_out_d = cnt_ext[cur_sel_d];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            cur_sel_q  <= DEFAULT_SEL;
            pend_sel_q <= DEFAULT_SEL;
            div_out_q  <= 1'b0;
            div_tick_q <= 1'b0;
            sel_ack_q  <= 1'b0;
            sel_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_sel_q  <= cur_sel_d;
            pend_sel_q <= pend_sel_d;
            div_out_q  <= div_out_d;
            div_tick_q <= div_out_d & ~div_out_q;
            sel_ack_q  <= (state_d == ACK);
            sel_err_q  <= err_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    assign sel_ack  = sel_ack_q;
    assign sel_err  = sel_err_q;
    assign busy     = busy_q;
    assign cur_sel  = cur_sel_q;
    assign div_out  = div_out_q;
    assign div_tick = div_tick_q;

endmodule

// File: tb/tb_div_sel_ctrl.sv
// tb/tb_div_sel_ctrl.sv - randomized handshake/reset stimulus against a cycle-level divider model
module tb_div_sel_ctrl;

    localparam int DEF_SEL = 0;
    localparam int N_CYC   = 6000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sel_req = 1'b0;
    logic [2:0] sel_val = 3'd0;
    logic       sel_ack, sel_err, busy, div_out, div_tick;
    logic [2:0] cur_sel;

    div_sel_ctrl #(.DEFAULT_SEL(3'd0)) dut (
        .clk      (clk),
        .reset    (reset),
        .sel_req  (sel_req),
        .sel_val  (sel_val),
        .sel_ack  (sel_ack),
        .sel_err  (sel_err),
        .busy     (busy),
        .cur_sel  (cur_sel),
        .div_out  (div_out),
        .div_tick (div_tick)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: mode 0 = idle, 1 = waiting for period end, 2 = acknowledged.
    int m_cnt, m_sel, m_pend, m_mode, m_err, m_div, m_tick;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step();
        int period;
        int prev;
        bit sw;
        if (!reset) begin
            m_cnt  = 0;
            m_sel  = DEF_SEL;
            m_pend = DEF_SEL;
            m_mode = 0;
            m_err  = 0;
            m_div  = 0;
            m_tick = 0;
        end else begin
            period = 2 ** (m_sel + 1);
            m_err  = 0;
            sw     = 1'b0;
            case (m_mode)
                0: if (sel_req) begin
                    if (int'(sel_val) > 4) begin
                        m_err  = 1;
                        m_mode = 2;
                    end else if (int'(sel_val) == m_sel) begin
                        m_mode = 2;
                    end else begin
                        m_pend = int'(sel_val);
                        m_mode = 1;
                    end
                end
                1: if ((m_cnt % period) == period - 1) begin
                    sw     = 1'b1;
                    m_mode = 2;
                end
                default: if (!sel_req) m_mode = 0;
            endcase
            if (sw) begin
                m_cnt = 0;
                m_sel = m_pend;
            end else begin
                m_cnt = (m_cnt + 1) % 32;
            end
            prev   = m_div;
            m_div  = (m_cnt / (2 ** m_sel)) % 2;
            m_tick = (m_div == 1 && prev == 0) ? 1 : 0;
        end
    endtask

    initial begin
        int  rst_left;
        int  hold;
        int  r;
        rst_left = 3;
        hold     = 0;
        for (int i = 0; i < N_CYC; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            cyc = i;
            check_eq("div_out",  32'(div_out),  32'(m_div));
            check_eq("div_tick", 32'(div_tick), 32'(m_tick));
            check_eq("cur_sel",  32'(cur_sel),  32'(m_sel));
            check_eq("sel_ack",  32'(sel_ack),  32'(m_mode == 2));
            check_eq("busy",     32'(busy),     32'(m_mode != 0));
            check_eq("sel_err",  32'(sel_err),  32'(m_err));

            if (rst_left == 0 && ($urandom % 400) == 0)
                rst_left = 1 + int'($urandom % 3);
            if (rst_left > 0) begin
                reset    = 1'b0;
                rst_left = rst_left - 1;
                // Occasionally leave the request up across reset to hit abandonment paths.
                if (($urandom % 2) == 0) sel_req = 1'b0;
            end else begin
                reset = 1'b1;
            end

            if (!sel_req) begin
                if (m_mode == 0 && ($urandom % 4) == 0) begin
                    sel_req = 1'b1;
                    r = int'($urandom % 20);
                    if (r < 5)       sel_val = 3'(m_sel);
                    else if (r < 8)  sel_val = 3'(5 + ($urandom % 3));
                    else             sel_val = 3'($urandom % 5);
                    hold = int'($urandom % 11);
                end
            end else if (m_mode == 2) begin
                if (hold == 0) sel_req = 1'b0;
                else hold = hold - 1;
            end else if (m_mode == 1) begin
                if (($urandom % 2) == 0) sel_val = 3'($urandom % 8);
                if (($urandom % 50) == 0) sel_req = 1'b0;
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_sel_ctrl.md
DIV_SEL_CTRL -- requirements
Module: div_sel_ctrl

Interface
REQ-001 The block SHALL have parameter DEFAULT_SEL, default 3'd0, giving the divide select loaded at reset (0=/2, 1=/4, 2=/8, 3=/16, 4=/32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock for all state.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on posedge clk.
REQ-004 The block SHALL have port sel_req, input, 1 bit: ratio-change request, 4-phase handshake.
REQ-005 The block SHALL have port sel_val, input, 3 bits: requested select, sampled when the request is accepted.
REQ-006 The block SHALL have port sel_ack, output, 1 bit: request completed; held high until sel_req is low.
REQ-007 The block SHALL have port sel_err, output, 1 bit: one-cycle pulse flagging a rejected (invalid) request.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in PENDING or ACK.
REQ-009 The block SHALL have port cur_sel, output, 3 bits: the active divide select.
REQ-010 The block SHALL have port div_out, output, 1 bit: divided clock, 50% duty, period 2^(cur_sel+1) clk cycles.
REQ-011 The block SHALL have port div_tick, output, 1 bit: one-cycle pulse in each cycle where div_out has just risen.

Function
REQ-012 The block SHALL contain a 5-bit free-running counter cnt that increments by 1 on every clk edge (mod 32) when not in reset.
REQ-013 div_out SHALL equal cnt[cur_sel] at all times and SHALL be sourced from a flop with no combinational decode on its output.
REQ-014 div_tick SHALL be registered and high exactly in the cycles where div_out=1 and div_out was 0 in the previous cycle.
REQ-015 The FSM SHALL have the states IDLE, PENDING and ACK.
REQ-016 In IDLE, sel_req=1 with sel_val<=4 and sel_val!=cur_sel SHALL latch sel_val into pend_sel and move the FSM to PENDING.
REQ-017 In IDLE, sel_req=1 with sel_val==cur_sel SHALL move the FSM directly to ACK without disturbing cnt.
REQ-018 In IDLE, sel_req=1 with sel_val in 5..7 SHALL pulse sel_err for one cycle, move the FSM to ACK, and leave cur_sel unchanged.
REQ-019 In PENDING, the boundary SHALL be detected when cnt[cur_sel:0] is all ones (last cycle of the current div_out period).
REQ-020 At the boundary edge, cnt SHALL load 0, cur_sel SHALL load pend_sel, and the FSM SHALL move to ACK.
REQ-021 div_out SHALL therefore never produce a high or low phase shorter than the shorter of the old and new half-periods.
REQ-022 In PENDING, changes on sel_val SHALL be ignored, and deassertion of sel_req SHALL NOT abort the switch.
REQ-023 In ACK, sel_ack SHALL be 1, and the FSM SHALL return to IDLE on the first edge where sel_req=0.
REQ-024 sel_ack SHALL be 0 in IDLE and PENDING.
REQ-025 A request SHALL NOT be accepted in the same cycle that the FSM returns to IDLE.
REQ-026 Worst-case latency from acceptance to sel_ack SHALL be 2^(cur_sel+1)+1 cycles (33 cycles for /32).

Reset
REQ-027 While reset=0 at a clk edge: cnt=0, cur_sel=DEFAULT_SEL, pend_sel=DEFAULT_SEL, FSM=IDLE, div_out=0, div_tick=0, sel_ack=0, sel_err=0, busy=0.
REQ-028 Reset asserted in PENDING or ACK SHALL abandon the request with no sel_ack and no change to cur_sel beyond the reset value.
REQ-029 On the first edge after reset deasserts, cnt SHALL become 1.

Verification
REQ-030 Reset release with DEFAULT_SEL=0: div_out SHALL be 1,0,1,0 on successive cycles, div_tick SHALL be high in cycles 1,3,5, and cur_sel SHALL be 0.
REQ-031 Change /2 to /8: sel_val=2 with sel_req held -> busy=1, switch at the next cnt[0]=1 edge, sel_ack high one cycle later, then div_out 4 low / 4 high.
REQ-032 Invalid request: sel_val=6 -> sel_err pulses one cycle, sel_ack=1, cur_sel unchanged, div_out period unchanged.
REQ-033 Same-value request: sel_val=cur_sel=1 -> sel_ack one cycle later, no cnt discontinuity, div_tick spacing stays 4.
REQ-034 Reset mid-PENDING from /32 to /2: reset=0 while waiting -> all outputs at reset values, sel_ack never asserted, cur_sel=DEFAULT_SEL.
REQ-035 Handshake hold: sel_req held 10 cycles after sel_ack -> sel_ack stays high all 10 cycles, exactly one switch, IDLE one cycle after sel_req falls.
